load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequences every MIPS load/store between the execute stage and the data memory block. It latches the request and computes the effective address. It then drives word-indexed memory read/write strobes, performs read-modify-write merging for sub-word stores, and sign/zero-extends sub-word loads. A one-cycle done pulse hands the result to writeback.

## Interface
Parameters:
- MEM_LATENCY, 1: cycles mem_read_data needs after sig_mem_read rises (1..15)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset; synchronous, active-low, sampled on rising clk
- start  in  1  request strobe; accepted only when busy=0
- opcode  in  6  0x20 lb, 0x21 lh, 0x23 lw, 0x24 lbu, 0x25 lhu, 0x28 sb, 0x29 sh, 0x2B sw
- base  in  32  rs register value
- offset  in  16  immediate, sign-extended internally
- store_data  in  32  rt register value
- busy  out  1  high from acceptance through the done cycle
- done  out  1  one-cycle completion pulse
- load_result  out  32  extended load value; held until next acceptance
- misaligned  out  1  valid with done; access aborted
- illegal_op  out  1  valid with done; opcode not in list
- mem_address  out  32  word index = ea[31:2] zero-extended
- mem_write_data  out  32  full word to store
- sig_mem_read  out  1  read strobe
- sig_mem_write  out  1  write strobe, exactly one cycle per store
- mem_read_data  in  32  word from memory

## Operation
- Acceptance: start=1 in IDLE latches opcode, store_data and ea = base + sext(offset). The add is mod 2^32 and the carry is dropped.
- Byte lanes are little-endian. Lane k = bits [8k+7:8k], with k = ea[1:0]. The halfword at ea[1]=0 is [15:0]; at ea[1]=1 it is [31:16].
- Alignment: lh/lhu/sh need ea[0]=0; lw/sw need ea[1:0]=0. On violation: no strobes; go to DONE with misaligned=1.
- Unknown opcode: no strobes; go to DONE with illegal_op=1. Illegal is checked before misaligned; only one flag is set.
- States:
  - IDLE: on accepted start, go to READ (loads, sb, sh), WRITE (sw), or DONE (fault).
  - READ: sig_mem_read=1; counter runs MEM_LATENCY cycles. On the last cycle, capture mem_read_data, then go to DONE (load) or WRITE (sb/sh).
  - WRITE: sig_mem_write=1 for one cycle; go to DONE.
  - DONE: done=1, busy=1; next state IDLE.
- sw writes store_data unchanged.
- sb/sh take the captured word, replace the addressed lane with store_data[7:0] or [15:0], leave other bits intact, and write the merged word.
- Loads: lb/lh sign-extend the selected lane, lbu/lhu zero-extend it, lw passes the word. Stores leave load_result unchanged.
- mem_address is held constant from acceptance through DONE.
- Fault flags clear on the next acceptance.
- start while busy=1 is ignored; no queueing.

## Timing
- Reset values: state IDLE, busy 0, done 0, load_result 0, misaligned 0, illegal_op 0, mem_address 0, mem_write_data 0, sig_mem_read 0, sig_mem_write 0.
- Reset mid-operation: state returns to IDLE at that edge and both strobes drop that edge. A pending write in that cycle is not issued.
- Latency counts edges from the accepting edge to the done cycle:
  - loads: MEM_LATENCY+1
  - sw: 2
  - sb/sh: MEM_LATENCY+2
  - faults: 1
- Back-to-back: start may be high in the DONE cycle. It is accepted at the edge that exits DONE only if busy would be 0. Therefore the minimum spacing is one IDLE cycle between operations.
- All outputs are registered; no combinational input-to-output path.

## Test plan
- Reset, then lw: base=0x100, offset=0x0004, MEM_LATENCY=1, memory word 0x41 = 0xDEADBEEF.
  - Expect mem_address=0x41 and sig_mem_read high for 1 cycle.
  - Expect done 2 cycles after acceptance with load_result=0xDEADBEEF.
- lb/lbu from word 0x80FF7F01 at ea=0x0C, 0x0D, 0x0E.
  - lb expects 0x00000001, 0x0000007F, 0xFFFFFFFF.
  - lbu at 0x0E expects 0x000000FF.
  - lh at ea=0x0E expects 0xFFFF80FF; lhu at 0x0E expects 0x000080FF.
- sb store_data=0x000000AA at ea=0x21 onto word 0x11223344.
  - Expect a read, then one write of 0x1122AA44 to mem_address 0x8.
  - Expect done at MEM_LATENCY+2.
- sh at ea=0x03 and lw at base=0x2, offset=0 (misaligned).
  - Expect misaligned=1 with done 1 cycle after acceptance and no strobes.
  - Opcode 0x22 expects illegal_op=1 and misaligned=0.
- MEM_LATENCY=3 lw with start held high throughout.
  - Expect a single accepted operation and sig_mem_read high for 3 cycles.
  - Expect a second acceptance only after the IDLE cycle.
- Assert rst_n=0 during the READ state of an sb.
  - Expect no sig_mem_write ever and all outputs at reset values the following cycle.
  - A following lw completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// MIPS load/store sequencer: latches a request, computes the effective address,
// drives word-indexed memory strobes, merges sub-word stores and extends sub-word loads.
module load_store_unit #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] base,
    input  logic [15:0] offset,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_result,
    output logic        misaligned,
    output logic        illegal_op,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        sig_mem_read,
    output logic        sig_mem_write,
    input  logic [31:0] mem_read_data
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  lane_q, lane_d;
    logic [15:0] sdata_q, sdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] load_result_q, load_result_d;
    logic        misaligned_q, misaligned_d;
    logic        illegal_op_q, illegal_op_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_write_data_q, mem_write_data_d;
    logic        sig_mem_read_q, sig_mem_read_d;
    logic        sig_mem_write_q, sig_mem_write_d;

    logic [31:0] ea;
    logic        op_legal;
    logic        op_misaligned;

    function automatic logic [31:0] extend_load(input logic [5:0] op, input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'b0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    // Only the addressed lane is replaced; all other bits of the read word survive.
    function automatic logic [31:0] merge_store(input logic [5:0] op, input logic [1:0] lane,
                                                input logic [31:0] word, input logic [15:0] sd);
        logic [31:0] m;
        m = word;
        if (op == OP_SB) begin
            m[8*lane +: 8] = sd[7:0];
        end else if (lane[1]) begin
            m[31:16] = sd;
        end else begin
            m[15:0] = sd;
        end
        return m;
    endfunction

    assign ea = base + {{16{offset[15]}}, offset};

    always_comb begin
        op_legal      = 1'b0;
        op_misaligned = 1'b0;
        case (opcode)
            OP_LB, OP_LBU, OP_SB: op_legal = 1'b1;
            OP_LH, OP_LHU, OP_SH: begin
                op_legal      = 1'b1;
                op_misaligned = ea[0];
            end
            OP_LW, OP_SW: begin
                op_legal      = 1'b1;
                op_misaligned = (ea[1:0] != 2'b00);
            end
            default: op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        op_d             = op_q;
        lane_d           = lane_q;
        sdata_d          = sdata_q;
        load_result_d    = load_result_q;
        misaligned_d     = misaligned_q;
        illegal_op_d     = illegal_op_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d          = opcode;
                    lane_d        = ea[1:0];
                    sdata_d       = store_data[15:0];
                    mem_address_d = {2'b00, ea[31:2]};
                    cnt_d         = 4'd0;
                    misaligned_d  = 1'b0;
                    illegal_op_d  = 1'b0;
                    if (!op_legal) begin
                        illegal_op_d = 1'b1;
                        state_d      = S_DONE;
                    end else if (op_misaligned) begin
                        misaligned_d = 1'b1;
                        state_d      = S_DONE;
                    end else if (opcode == OP_SW) begin
                        mem_write_data_d = store_data;
                        state_d          = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (cnt_q == LAST_CNT) begin
                    if (op_q == OP_SB || op_q == OP_SH) begin
                        mem_write_data_d = merge_store(op_q, lane_q, mem_read_data, sdata_q);
                        state_d          = S_WRITE;
                    end else begin
                        load_result_d = extend_load(op_q, lane_q, mem_read_data);
                        state_d       = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Registered outputs are decoded from the state being entered.
        busy_d          = (state_d != S_IDLE);
        done_d          = (state_d == S_DONE);
        sig_mem_read_d  = (state_d == S_READ);
        sig_mem_write_d = (state_d == S_WRITE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            cnt_q            <= 4'd0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            load_result_q    <= 32'd0;
            misaligned_q     <= 1'b0;
            illegal_op_q     <= 1'b0;
            mem_address_q    <= 32'd0;
            mem_write_data_q <= 32'd0;
            sig_mem_read_q   <= 1'b0;
            sig_mem_write_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            load_result_q    <= load_result_d;
            misaligned_q     <= misaligned_d;
            illegal_op_q     <= illegal_op_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            sig_mem_read_q   <= sig_mem_read_d;
            sig_mem_write_q  <= sig_mem_write_d;
        end
    end

    // Request fields are only consumed after acceptance, so they need no reset.
    always_ff @(posedge clk) begin
        op_q    <= op_d;
        lane_q  <= lane_d;
        sdata_q <= sdata_d;
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign load_result    = load_result_q;
    assign misaligned     = misaligned_q;
    assign illegal_op     = illegal_op_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;
    assign sig_mem_read   = sig_mem_read_q;
    assign sig_mem_write  = sig_mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: two load_store_unit instances (MEM_LATENCY 1 and 3) against a
// word-array reference model, with directed cases followed by random traffic.
module tb_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_s  [2];
    logic        start_s  [2];
    logic [5:0]  opcode_s [2];
    logic [31:0] base_s   [2];
    logic [15:0] offset_s [2];
    logic [31:0] sd_s     [2];
    logic [31:0] mrd_s    [2];

    wire         busy_w [2];
    wire         done_w [2];
    wire  [31:0] lr_w   [2];
    wire         mis_w  [2];
    wire         ill_w  [2];
    wire  [31:0] addr_w [2];
    wire  [31:0] wd_w   [2];
    wire         rd_w   [2];
    wire         wr_w   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        load_store_unit #(.MEM_LATENCY((g == 0) ? 1 : 3)) u_dut (
            .clk            (clk),
            .rst_n          (rst_n_s[g]),
            .start          (start_s[g]),
            .opcode         (opcode_s[g]),
            .base           (base_s[g]),
            .offset         (offset_s[g]),
            .store_data     (sd_s[g]),
            .busy           (busy_w[g]),
            .done           (done_w[g]),
            .load_result    (lr_w[g]),
            .misaligned     (mis_w[g]),
            .illegal_op     (ill_w[g]),
            .mem_address    (addr_w[g]),
            .mem_write_data (wd_w[g]),
            .sig_mem_read   (rd_w[g]),
            .sig_mem_write  (wr_w[g]),
            .mem_read_data  (mrd_s[g])
        );
    end

    logic [31:0] mem    [2][256];
    logic [31:0] refmem [2][256];
    logic [31:0] exp_lr [2];
    int          rd_cnt   [2] = '{0, 0};
    int          rd_total [2] = '{0, 0};
    int          wr_total [2] = '{0, 0};
    logic [31:0] last_wa  [2];
    logic [31:0] last_wd  [2];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Memory: data is only valid on the last cycle of the latency window.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (wr_w[g]) begin
                mem[g][addr_w[g][7:0]] <= wd_w[g];
                wr_total[g] <= wr_total[g] + 1;
                last_wa[g]  <= addr_w[g];
                last_wd[g]  <= wd_w[g];
            end
            if (rd_w[g]) begin
                rd_total[g] <= rd_total[g] + 1;
                rd_cnt[g]   <= rd_cnt[g] + 1;
            end else begin
                rd_cnt[g] <= 0;
            end
        end
    end

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            mrd_s[g] = 32'hBAD0_0BAD;
            if (rd_w[g] && rd_cnt[g] == lat_of(g) - 1) mrd_s[g] = mem[g][addr_w[g][7:0]];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic check_reset_outputs(input int d);
        check_val("rst_busy",  32'(busy_w[d]), 32'd0);
        check_val("rst_done",  32'(done_w[d]), 32'd0);
        check_val("rst_lr",    lr_w[d], 32'd0);
        check_val("rst_mis",   32'(mis_w[d]), 32'd0);
        check_val("rst_ill",   32'(ill_w[d]), 32'd0);
        check_val("rst_addr",  addr_w[d], 32'd0);
        check_val("rst_wdata", wd_w[d], 32'd0);
        check_val("rst_rd",    32'(rd_w[d]), 32'd0);
        check_val("rst_wr",    32'(wr_w[d]), 32'd0);
    endtask

    task automatic run_op(input int d, input logic [5:0] op, input logic [31:0] b,
                          input logic [15:0] off, input logic [31:0] sd, input bit hold,
                          output logic [31:0] got);
        logic [31:0] ea, word, nw;
        logic [63:0] mask, v;
        int size, sh, lat, exp_rd, exp_wr, cycles, rd0, wr0, l;
        bit legal, mis, is_load, sgn;
        l       = lat_of(d);
        ea      = b + 32'($signed(off));
        legal   = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
        size    = (op == 6'h20 || op == 6'h24 || op == 6'h28) ? 1 :
                  (op == 6'h21 || op == 6'h25 || op == 6'h29) ? 2 : 4;
        is_load = (op < 6'h28);
        sgn     = (op == 6'h20 || op == 6'h21);
        mis     = legal && (ea % size != 0);
        sh      = 8 * int'(ea % 4);
        mask    = (64'd1 << (8 * size)) - 64'd1;
        word    = refmem[d][ea[9:2]];
        nw      = word;
        exp_rd  = 0;
        exp_wr  = 0;
        lat     = 1;
        if (legal && !mis) begin
            if (is_load) begin
                v = ({32'd0, word} >> sh) & mask;
                if (sgn && v[8*size-1]) v = v | ~mask;
                exp_lr[d] = v[31:0];
                lat    = l + 1;
                exp_rd = l;
            end else begin
                v  = ({32'd0, word} & ~(mask << sh)) | (({32'd0, sd} & mask) << sh);
                nw = v[31:0];
                exp_wr = 1;
                lat    = (size == 4) ? 2 : l + 2;
                exp_rd = (size == 4) ? 0 : l;
            end
        end

        @(negedge clk);
        opcode_s[d] = op;
        base_s[d]   = b;
        offset_s[d] = off;
        sd_s[d]     = sd;
        start_s[d]  = 1'b1;
        rd0 = rd_total[d];
        wr0 = wr_total[d];
        @(posedge clk);
        @(negedge clk);
        if (!hold) start_s[d] = 1'b0;
        cycles = 1;
        while (!done_w[d] && cycles < 40) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        got = lr_w[d];
        check_val("done_seen", 32'(done_w[d]), 32'd1);
        check_val("latency",   32'(cycles), 32'(lat));
        check_val("busy_done", 32'(busy_w[d]), 32'd1);
        check_val("illegal",   32'(ill_w[d]), 32'(!legal));
        check_val("misalign",  32'(mis_w[d]), 32'(mis));
        check_val("load_res",  lr_w[d], exp_lr[d]);
        check_val("rd_cycles", 32'(rd_total[d] - rd0), 32'(exp_rd));
        check_val("wr_count",  32'(wr_total[d] - wr0), 32'(exp_wr));
        check_val("strobes_off", 32'({rd_w[d], wr_w[d]}), 32'd0);
        if (legal && !mis) check_val("mem_addr", addr_w[d], {2'b00, ea[31:2]});
        if (exp_wr == 1) begin
            check_val("wr_data", last_wd[d], nw);
            check_val("wr_addr", last_wa[d], {2'b00, ea[31:2]});
            refmem[d][ea[9:2]] = nw;
            check_val("mem_word", mem[d][ea[9:2]], nw);
        end
    endtask

    initial begin
        logic [31:0] got, got1;
        logic [5:0]  ops [10];
        int          cycles, wr0, rd0, o;
        ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h22, 6'h3F};
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 256; i++) begin
                mem[g][i]    = $urandom;
                refmem[g][i] = mem[g][i];
            end
            rst_n_s[g]  = 1'b0;
            start_s[g]  = 1'b0;
            opcode_s[g] = 6'h0;
            base_s[g]   = 32'd0;
            offset_s[g] = 16'd0;
            sd_s[g]     = 32'd0;
            exp_lr[g]   = 32'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs(0);
        rst_n_s[0] = 1'b1;
        rst_n_s[1] = 1'b1;

        // lw from word 0x41
        mem[0][8'h41] = 32'hDEADBEEF;
        refmem[0][8'h41] = 32'hDEADBEEF;
        run_op(0, 6'h23, 32'h100, 16'h0004, 32'd0, 1'b0, got);
        check_val("lw_literal", got, 32'hDEADBEEF);

        // Sub-word loads from 0x80FF7F01 at word 3
        mem[0][3] = 32'h80FF7F01;
        refmem[0][3] = 32'h80FF7F01;
        run_op(0, 6'h20, 32'h0C, 16'h0, 32'd0, 1'b0, got);
        check_val("lb_0c", got, 32'h00000001);
        run_op(0, 6'h20, 32'h0D, 16'h0, 32'd0, 1'b0, got);
        check_val("lb_0d", got, 32'h0000007F);
        run_op(0, 6'h20, 32'h0E, 16'h0, 32'd0, 1'b0, got);
        check_val("lb_0e", got, 32'hFFFFFFFF);
        run_op(0, 6'h24, 32'h0E, 16'h0, 32'd0, 1'b0, got);
        check_val("lbu_0e", got, 32'h000000FF);
        run_op(0, 6'h21, 32'h0E, 16'h0, 32'd0, 1'b0, got);
        check_val("lh_0e", got, 32'hFFFF80FF);
        run_op(0, 6'h25, 32'h0E, 16'h0, 32'd0, 1'b0, got);
        check_val("lhu_0e", got, 32'h000080FF);

        // sb merge onto 0x11223344
        mem[0][8] = 32'h11223344;
        refmem[0][8] = 32'h11223344;
        run_op(0, 6'h28, 32'h21, 16'h0, 32'h000000AA, 1'b0, got);
        check_val("sb_merge", mem[0][8], 32'h1122AA44);

        // Faults
        run_op(0, 6'h29, 32'h03, 16'h0, 32'h1234, 1'b0, got);
        run_op(0, 6'h23, 32'h02, 16'h0, 32'd0, 1'b0, got);
        run_op(0, 6'h22, 32'h40, 16'h0, 32'd0, 1'b0, got);
        check_val("ill_only", 32'({ill_w[0], mis_w[0]}), 32'b10);

        // MEM_LATENCY=3 lw with start held high
        run_op(1, 6'h23, 32'h200, 16'hFFFC, 32'd0, 1'b1, got1);
        @(posedge clk);
        @(negedge clk);
        check_val("hold_gap_busy", 32'(busy_w[1]), 32'd0);
        rd0 = rd_total[1];
        @(posedge clk);
        @(negedge clk);
        check_val("hold_reaccept", 32'(busy_w[1]), 32'd1);
        start_s[1] = 1'b0;
        cycles = 1;
        while (!done_w[1] && cycles < 40) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        check_val("hold2_latency", 32'(cycles), 32'd4);
        check_val("hold2_lr", lr_w[1], got1);
        check_val("hold2_rd", 32'(rd_total[1] - rd0), 32'd3);

        // Reset during READ of an sb
        @(negedge clk);
        opcode_s[1] = 6'h28;
        base_s[1]   = 32'h40;
        offset_s[1] = 16'h0001;
        sd_s[1]     = 32'h5A;
        start_s[1]  = 1'b1;
        wr0 = wr_total[1];
        @(posedge clk);
        @(negedge clk);
        start_s[1] = 1'b0;
        check_val("pre_rst_read", 32'(rd_w[1]), 32'd1);
        rst_n_s[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs(1);
        rst_n_s[1] = 1'b1;
        exp_lr[1]  = 32'd0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_val("rst_no_write", 32'(wr_total[1] - wr0), 32'd0);
        check_val("rst_mem_kept", mem[1][8'h10], refmem[1][8'h10]);
        run_op(1, 6'h23, 32'h44, 16'h0, 32'd0, 1'b0, got);

        // Random traffic on both latencies
        for (int i = 0; i < 90; i++) begin
            int d;
            d = (i < 60) ? 0 : 1;
            o = int'($urandom_range(0, 31)) - 16;
            run_op(d, ops[$urandom_range(0, 9)], 32'($urandom_range(16, 32'h3E0)),
                   o[15:0], $urandom, 1'b0, got);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
